commit_sequencer: RTL and testbench
===================================

Name: commit_sequencer

Overview:
Sits between the core's retirement trace and the ISA checker in the formal harness. Buffers per-instruction commit records (PC, instruction, trap event, memory access) and merges load data that returns after the commit. Issues complete records in order to the checker over a valid/ready handshake, and back-pressures the core when full. Also keeps a commit counter and sticky hang and protocol-error flags for harness assertions.

Parameters:
DEPTH, 4, buffer entries; power of two, 2..16
XLEN, 32, data/address width
MEMW_W, 6, memWidth field width
TIMEOUT, 64, cycles without an issued commit before hang sets

Ports:
clock  input  1  sole clock
reset  input  1  synchronous, active-low (0 = reset)
in_valid / in_ready  input / output  1 / 1  core commit handshake
in_pc, in_inst  input  XLEN each  committed PC and instruction
in_event_valid, in_event_cause  input  1, XLEN  trap record and its cause
in_mem_read_valid, in_mem_read_addr, in_mem_read_memWidth  input  1, XLEN, MEMW_W  load issued by this commit
in_mem_write_valid, in_mem_write_addr, in_mem_write_memWidth, in_mem_write_data  input  1, XLEN, MEMW_W, XLEN  store
rdata_valid, rdata  input  1, XLEN  late load data, in load order
out_valid / out_ready  output / input  1 / 1  checker handshake
out_pc, out_inst, out_event_valid, out_event_cause  output  as the in_ fields  head record
out_mem_read_valid/addr/memWidth/data, out_mem_write_valid/addr/memWidth/data  output  as the in_ fields  head memory record
commit_count  output  32  number of records issued; wraps
hang  output  1  sticky watchdog flag
proto_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (reset==0 at clock edge):
  - pointers, count, pending flags, commit_count, watchdog, hang and proto_err all clear.
  - out_valid=0. All out_* fields read 0; storage is cleared.
  - in_ready=1 on the first cycle after reset.
  - Reset mid-operation discards every buffered entry and any outstanding rdata expectation.
- Storage:
  - Circular buffer with wr_ptr, rd_ptr and fill_ptr. Pointers are log2(DEPTH)+1 bits so full and empty are distinct.
  - count = wr_ptr - rd_ptr.
- Push:
  - in_ready = (count < DEPTH), combinational from registered state. No pass-through when full.
  - On in_valid && in_ready, the entry is written at wr_ptr.
  - If in_event_valid=1, both mem valids are stored as 0 (a trapping instruction has no memory effect).
  - The entry's rd_pending flag = in_mem_read_valid && !in_event_valid.
- Load-data fill:
  - On rdata_valid, rdata is written to the oldest entry with rd_pending=1 (located via fill_ptr), and that flag clears.
  - If no entry is pending but the same cycle pushes an entry with rd_pending, the data is captured directly into the new entry, which is written complete.
  - rdata_valid with no pending target sets proto_err; the data is dropped.
- Issue:
  - out_valid = (count != 0) && !rd_pending[head]. out_* fields are driven from head storage (zero added latency beyond storage).
  - Minimum latency from push to out_valid is 1 cycle for a record without a pending load.
  - Pop on out_valid && out_ready: rd_ptr increments and commit_count increments.
  - Push and pop in the same cycle leave count unchanged.
  - A non-ready head blocks younger complete entries; order is strict.
- Watchdog:
  - 16-bit idle counter clears on every pop and otherwise increments, saturating.
  - At idle == TIMEOUT, hang sets and stays set until reset.
- Once out_valid is high, the out_* fields are held stable until the pop.

Decomposition:
- Package commit_seq_pkg holds:
  - XLEN and MEMW_W constants;
  - commit_entry_t struct (pc, inst, event_valid, event_cause, read and write sub-structs, rd_pending);
  - mem_access_t struct (valid, addr, memWidth, data).
- One sub-module, commit_seq_buffer: the storage array with pointer logic and the fill_ptr search.
- Handshake, watchdog and counters stay in commit_sequencer.

Test Plan:
- Reset, then push pc=0x80000000 inst=0x00100093 with no mem op, out_ready=1 -> out_valid=1 the next cycle with out_pc=0x80000000; after the pop, commit_count=1.
- Push a load (addr=0x100, memWidth=32) with rdata arriving 3 cycles later as 0xDEADBEEF -> out_valid stays 0 until the cycle after rdata, then out_mem_read_data=0xDEADBEEF.
- Push a load then an ALU op; rdata arrives after both pushes -> issue order is load then ALU, and the ALU record waits behind the load.
- Hold out_ready=0 and push 5 records with DEPTH=4 -> in_ready=0 after the 4th push; the 5th record is accepted only after one pop.
- Push an event with cause=2 and in_mem_write_valid=1 -> out_event_valid=1, out_event_cause=2, out_mem_write_valid=0. rdata_valid pulsed while nothing is pending -> proto_err=1 and stays 1.
- No pushes for 64 cycles after reset -> hang=1. Assert reset low mid-stream with 3 entries buffered -> out_valid=0, in_ready=1, commit_count=0 after reset.

Source files
------------

// File: rtl/commit_seq_pkg.sv
// Shared widths and record types for the commit sequencer.
package commit_seq_pkg;

    localparam int XLEN   = 32;
    localparam int MEMW_W = 6;

    // One memory access attached to a commit record.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   addr;
        logic [MEMW_W-1:0] memWidth;
        logic [XLEN-1:0]   data;
    } mem_access_t;

    // One buffered commit; rd_pending marks a load still waiting for its data.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            event_valid;
        logic [XLEN-1:0] event_cause;
        mem_access_t     rd;
        mem_access_t     wr;
        logic            rd_pending;
    } commit_entry_t;

endpackage

// File: rtl/commit_seq_buffer.sv
// Circular commit-record store with in-order load-data fill.
// The fill target is the oldest buffered entry still waiting for load data;
// loads return in issue order, so that entry always owns the next rdata beat.
module commit_seq_buffer
    import commit_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  commit_entry_t            push_entry,
    input  logic                     pop,
    input  logic                     rdata_valid,
    input  logic [XLEN-1:0]          rdata,
    output commit_entry_t            head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     fill_miss
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    commit_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] fill_ptr, idx;
    logic          fill_hit, capture_new;
    commit_entry_t new_entry;

    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    // Locate the oldest live entry that still waits for load data.
    always_comb begin
        fill_hit = 1'b0;
        fill_ptr = rd_ptr[AW-1:0];
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr[AW-1:0] + AW'(i);
            if (!fill_hit && (PW'(i) < count) && mem[idx].rd_pending) begin
                fill_hit = 1'b1;
                fill_ptr = idx;
            end
        end
    end

    // With nothing older pending, data arriving alongside a new load belongs to it.
    always_comb begin
        capture_new = rdata_valid && !fill_hit && push && push_entry.rd_pending;
        fill_miss   = rdata_valid && !fill_hit && !capture_new;
        new_entry   = push_entry;
        if (capture_new) begin
            new_entry.rd.data    = rdata;
            new_entry.rd_pending = 1'b0;
        end
    end

    // Storage and pointer update; push never targets a live slot, so it cannot collide with a fill.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= new_entry;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (rdata_valid && fill_hit) begin
                mem[fill_ptr].rd.data    <= rdata;
                mem[fill_ptr].rd_pending <= 1'b0;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/commit_sequencer.sv
// Commit sequencer: buffers retirement records, merges late load data and
// issues complete records in order, with commit counter and hang/protocol flags.
module commit_sequencer
    import commit_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_inst,
    input  logic              in_event_valid,
    input  logic [XLEN-1:0]   in_event_cause,
    input  logic              in_mem_read_valid,
    input  logic [XLEN-1:0]   in_mem_read_addr,
    input  logic [MEMW_W-1:0] in_mem_read_memWidth,
    input  logic              in_mem_write_valid,
    input  logic [XLEN-1:0]   in_mem_write_addr,
    input  logic [MEMW_W-1:0] in_mem_write_memWidth,
    input  logic [XLEN-1:0]   in_mem_write_data,
    input  logic              rdata_valid,
    input  logic [XLEN-1:0]   rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_inst,
    output logic              out_event_valid,
    output logic [XLEN-1:0]   out_event_cause,
    output logic              out_mem_read_valid,
    output logic [XLEN-1:0]   out_mem_read_addr,
    output logic [MEMW_W-1:0] out_mem_read_memWidth,
    output logic [XLEN-1:0]   out_mem_read_data,
    output logic              out_mem_write_valid,
    output logic [XLEN-1:0]   out_mem_write_addr,
    output logic [MEMW_W-1:0] out_mem_write_memWidth,
    output logic [XLEN-1:0]   out_mem_write_data,
    output logic [31:0]       commit_count,
    output logic              hang,
    output logic              proto_err
);

    localparam int PW = $clog2(DEPTH) + 1;

    commit_entry_t push_entry, head;
    logic [PW-1:0] count;
    logic          push, pop, fill_miss;
    logic [15:0]   idle;

    assign in_ready  = count < PW'(DEPTH);
    assign out_valid = (count != '0) && !head.rd_pending;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Build the stored record; a trapping instruction carries no memory effect.
    always_comb begin
        push_entry                = '0;
        push_entry.pc             = in_pc;
        push_entry.inst           = in_inst;
        push_entry.event_valid    = in_event_valid;
        push_entry.event_cause    = in_event_cause;
        push_entry.rd.valid       = in_mem_read_valid && !in_event_valid;
        push_entry.rd.addr        = in_mem_read_addr;
        push_entry.rd.memWidth    = in_mem_read_memWidth;
        push_entry.wr.valid       = in_mem_write_valid && !in_event_valid;
        push_entry.wr.addr        = in_mem_write_addr;
        push_entry.wr.memWidth    = in_mem_write_memWidth;
        push_entry.wr.data        = in_mem_write_data;
        push_entry.rd_pending     = in_mem_read_valid && !in_event_valid;
    end

    commit_seq_buffer #(.DEPTH(DEPTH)) u_buf (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .head        (head),
        .count       (count),
        .fill_miss   (fill_miss)
    );

    assign out_pc                 = head.pc;
    assign out_inst               = head.inst;
    assign out_event_valid        = head.event_valid;
    assign out_event_cause        = head.event_cause;
    assign out_mem_read_valid     = head.rd.valid;
    assign out_mem_read_addr      = head.rd.addr;
    assign out_mem_read_memWidth  = head.rd.memWidth;
    assign out_mem_read_data      = head.rd.data;
    assign out_mem_write_valid    = head.wr.valid;
    assign out_mem_write_addr     = head.wr.addr;
    assign out_mem_write_memWidth = head.wr.memWidth;
    assign out_mem_write_data     = head.wr.data;

    // Commit counter, idle watchdog and sticky error flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            commit_count <= '0;
            idle         <= '0;
            hang         <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            if (pop) begin
                commit_count <= commit_count + 32'd1;
                idle         <= '0;
            end else if (idle != 16'hFFFF) begin
                idle <= idle + 16'd1;
            end
            if (idle == 16'(TIMEOUT)) hang <= 1'b1;
            if (fill_miss) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_commit_sequencer.sv
// Directed bench for commit_sequencer: stimulus queues expected records,
// a negedge monitor pops and compares each record the DUT issues.
module tb_commit_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_pc = '0, in_inst = '0;
    logic        in_event_valid = 1'b0;
    logic [31:0] in_event_cause = '0;
    logic        in_mem_read_valid = 1'b0;
    logic [31:0] in_mem_read_addr = '0;
    logic [5:0]  in_mem_read_memWidth = '0;
    logic        in_mem_write_valid = 1'b0;
    logic [31:0] in_mem_write_addr = '0;
    logic [5:0]  in_mem_write_memWidth = '0;
    logic [31:0] in_mem_write_data = '0;
    logic        rdata_valid = 1'b0;
    logic [31:0] rdata = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_pc, out_inst, out_event_cause;
    logic        out_event_valid;
    logic        out_mem_read_valid, out_mem_write_valid;
    logic [31:0] out_mem_read_addr, out_mem_read_data, out_mem_write_addr, out_mem_write_data;
    logic [5:0]  out_mem_read_memWidth, out_mem_write_memWidth;
    logic [31:0] commit_count;
    logic        hang, proto_err;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ev;
        logic [31:0] cause;
        logic        rv;
        logic [31:0] raddr;
        logic [5:0]  rw;
        logic [31:0] rdata;
        logic        wv;
        logic [31:0] waddr;
        logic [5:0]  ww;
        logic [31:0] wdata;
    } rec_t;

    rec_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    commit_sequencer #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .in_event_valid(in_event_valid), .in_event_cause(in_event_cause),
        .in_mem_read_valid(in_mem_read_valid), .in_mem_read_addr(in_mem_read_addr),
        .in_mem_read_memWidth(in_mem_read_memWidth),
        .in_mem_write_valid(in_mem_write_valid), .in_mem_write_addr(in_mem_write_addr),
        .in_mem_write_memWidth(in_mem_write_memWidth), .in_mem_write_data(in_mem_write_data),
        .rdata_valid(rdata_valid), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst),
        .out_event_valid(out_event_valid), .out_event_cause(out_event_cause),
        .out_mem_read_valid(out_mem_read_valid), .out_mem_read_addr(out_mem_read_addr),
        .out_mem_read_memWidth(out_mem_read_memWidth), .out_mem_read_data(out_mem_read_data),
        .out_mem_write_valid(out_mem_write_valid), .out_mem_write_addr(out_mem_write_addr),
        .out_mem_write_memWidth(out_mem_write_memWidth), .out_mem_write_data(out_mem_write_data),
        .commit_count(commit_count), .hang(hang), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Advance n cycles, landing just after the rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Offer one record; on acceptance queue its expected issued form.
    task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                        input logic ev, input logic [31:0] cause,
                        input logic rv, input logic [31:0] raddr,
                        input logic wv, input logic [31:0] waddr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata);
        rec_t e;
        int   n;
        in_valid = 1'b1; in_pc = pc; in_inst = inst;
        in_event_valid = ev; in_event_cause = cause;
        in_mem_read_valid = rv; in_mem_read_addr = raddr; in_mem_read_memWidth = 6'd32;
        in_mem_write_valid = wv; in_mem_write_addr = waddr; in_mem_write_memWidth = 6'd32;
        in_mem_write_data = wdata;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL push_timeout: pc %h never accepted, in_ready=%b", pc, in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        e.pc = pc; e.inst = inst; e.ev = ev; e.cause = cause;
        e.rv = rv && !ev; e.raddr = raddr; e.rw = 6'd32; e.rdata = exp_rdata;
        e.wv = wv && !ev; e.waddr = waddr; e.ww = 6'd32; e.wdata = wdata;
        exp_q.push_back(e);
    endtask

    // Monitor: every issued record must match the oldest expected one.
    always @(negedge clock) begin : monitor
        rec_t act, e;
        if (reset && out_valid && out_ready) begin
            act.pc = out_pc; act.inst = out_inst;
            act.ev = out_event_valid; act.cause = out_event_cause;
            act.rv = out_mem_read_valid; act.raddr = out_mem_read_addr;
            act.rw = out_mem_read_memWidth; act.rdata = out_mem_read_data;
            act.wv = out_mem_write_valid; act.waddr = out_mem_write_addr;
            act.ww = out_mem_write_memWidth; act.wdata = out_mem_write_data;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_record: got pc %h, expected no record", out_pc);
            end else begin
                e = exp_q.pop_front();
                if (act === e) pass_cnt++;
                else $display("FAIL record: got %h, expected %h", act, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        cyc(2);
        @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_commit_count", commit_count, 32'd0);
        check("rst_hang", 32'(hang), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_wdata", out_mem_write_data, 32'd0);
        cyc(1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        cyc(1);

        // Simple ALU record: issued one cycle after push
        out_ready = 1'b1;
        push(32'h80000000, 32'h00100093, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("alu_out_valid", 32'(out_valid), 32'd1);
        check("alu_out_pc", out_pc, 32'h80000000);
        cyc(1);
        @(negedge clock);
        check("alu_commit_count", commit_count, 32'd1);
        cyc(1);

        // Load with data three cycles after the push
        push(32'h80000004, 32'h00012083, 0, 0, 1, 32'h100, 0, 0, 0, 32'hDEADBEEF);
        @(negedge clock);
        check("load_wait1", 32'(out_valid), 32'd0);
        cyc(1);
        @(negedge clock);
        check("load_wait2", 32'(out_valid), 32'd0);
        cyc(1);
        rdata_valid = 1'b1; rdata = 32'hDEADBEEF;
        @(negedge clock);
        check("load_wait3", 32'(out_valid), 32'd0);
        cyc(1);
        rdata_valid = 1'b0;
        @(negedge clock);
        check("load_out_valid", 32'(out_valid), 32'd1);
        check("load_out_data", out_mem_read_data, 32'hDEADBEEF);
        cyc(2);

        // Load then ALU: the ALU waits behind the pending load
        push(32'h80000010, 32'h00412103, 0, 0, 1, 32'h104, 0, 0, 0, 32'h12345678);
        push(32'h80000014, 32'h00208133, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("alu_blocked", 32'(out_valid), 32'd0);
        cyc(1);
        rdata_valid = 1'b1; rdata = 32'h12345678;
        cyc(1);
        rdata_valid = 1'b0;
        cyc(4);

        // Full buffer back-pressure
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'h80000020 + 32'(4 * i), 32'h00000013, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("full_in_ready", 32'(in_ready), 32'd0);
        cyc(1);
        fork
            push(32'h80000030, 32'h00000013, 0, 0, 0, 0, 0, 0, 0, 0);
            begin
                cyc(2);
                @(negedge clock);
                check("full_hold", 32'(in_ready), 32'd0);
                cyc(1);
                out_ready = 1'b1;
                cyc(1);
                out_ready = 1'b0;
            end
        join
        @(negedge clock);
        check("refull_in_ready", 32'(in_ready), 32'd0);
        cyc(1);
        out_ready = 1'b1;
        cyc(8);

        // Trapping instruction drops its store
        push(32'h80000040, 32'h00000073, 1, 32'd2, 0, 0, 1, 32'h200, 32'hCAFEF00D, 0);
        cyc(3);

        // Load data arriving in the same cycle as its own push
        rdata_valid = 1'b1; rdata = 32'h0BADF00D;
        push(32'h80000044, 32'h00812183, 0, 0, 1, 32'h108, 0, 0, 0, 32'h0BADF00D);
        rdata_valid = 1'b0;
        cyc(3);
        @(negedge clock);
        check("no_spurious_proto", 32'(proto_err), 32'd0);
        cyc(1);

        // Unsolicited load data
        rdata_valid = 1'b1; rdata = 32'h11111111;
        cyc(1);
        rdata_valid = 1'b0;
        @(negedge clock);
        check("proto_err_set", 32'(proto_err), 32'd1);
        cyc(3);
        @(negedge clock);
        check("proto_err_sticky", 32'(proto_err), 32'd1);
        cyc(1);

        // Reset with three records (one a pending load) buffered
        out_ready = 1'b0;
        push(32'h80000050, 32'h00000013, 0, 0, 0, 0, 0, 0, 0, 0);
        push(32'h80000054, 32'h00c12203, 0, 0, 1, 32'h10C, 0, 0, 0, 0);
        push(32'h80000058, 32'h00000013, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        cyc(1);
        reset = 1'b0;
        exp_q.delete();
        cyc(1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_commit_count", commit_count, 32'd0);
        check("mid_rst_proto_err", 32'(proto_err), 32'd0);
        cyc(1);
        rdata_valid = 1'b1; rdata = 32'h22222222;
        cyc(1);
        rdata_valid = 1'b0;
        @(negedge clock);
        check("stale_load_dropped", 32'(proto_err), 32'd1);
        cyc(1);

        // Watchdog: idle since reset
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(60);
        @(negedge clock);
        check("hang_early", 32'(hang), 32'd0);
        cyc(10);
        @(negedge clock);
        check("hang_set", 32'(hang), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
